// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch front end: it assembles 24-bit little-endian words into a prefetch FIFO.
// Optional build macro FETCH_COUNT_EN adds the fetch_count output, a 16-bit count of pops.
module instruction_fetch #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DEPTH_LOG2 = 2,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [23:0]       next_instruction,
  output logic              next_instruction_available,
  input  logic              ready_for_next_instruction,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_address,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Handshakes: the FIFO head is popped on a clk edge where next_instruction_available
  // and ready_for_next_instruction are both high; a memory request completes on a clk
  // edge where mem_read and mem_valid are both high.
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [15:0]        asm_q, asm_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [23:0]        fifo_q [DEPTH];

  logic               fifo_empty;
  logic               pop;
  logic               capture;
  logic               push;
  logic               full_next;
  logic [23:0]        push_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & ~jump_valid & ready_for_next_instruction;
  assign capture    = (state_q == ST_FETCH) & mem_valid;
  assign push_word  = {mem_data, asm_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    full_next  = 1'b0;

    if (jump_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      byte_cnt_d = 2'd0;
      pc_d       = jump_address;
      // A request still in flight must be answered before the new address can go out.
      unique case (state_q)
        ST_FETCH: begin
          if (mem_valid) begin
            addr_d  = jump_address;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_WAIT: begin
          addr_d  = jump_address;
          state_d = ST_FETCH;
        end
        default: begin
          if (mem_valid) begin
            addr_d  = jump_address;
            state_d = ST_FETCH;
          end
        end
      endcase
    end else begin
      if (capture) begin
        pc_d   = pc_q + 1'b1;
        addr_d = pc_q + 1'b1;
        unique case (byte_cnt_q)
          2'd0: begin
            asm_d[7:0] = mem_data;
            byte_cnt_d = 2'd1;
          end
          2'd1: begin
            asm_d[15:8] = mem_data;
            byte_cnt_d  = 2'd2;
          end
          default: begin
            push       = 1'b1;
            byte_cnt_d = 2'd0;
          end
        endcase
      end

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      full_next = (count_d == CNT_W'(DEPTH));

      // Byte 0 of a new word is only requested once a FIFO slot is guaranteed.
      unique case (state_q)
        ST_FETCH: begin
          if (capture && (byte_cnt_d == 2'd0) && full_next) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (!full_next) state_d = ST_FETCH;
        end
        default: begin
          if (mem_valid) begin
            addr_d  = pc_q;
            state_d = full_next ? ST_WAIT : ST_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_word;
  end

  assign next_instruction_available = ~fifo_empty & ~jump_valid;
  assign next_instruction           = fifo_empty ? 24'd0 : fifo_q[rd_ptr_q];
  assign mem_read                   = ~reset & (state_q != ST_WAIT);
  assign mem_addr                   = addr_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pop) fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_count_q <= 16'd0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table, directed multi-cycle sequences, and a
// randomized run whose popped words are checked against a byte-stream model of memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] next_instruction;
  logic        next_instruction_available;
  logic        ready_for_next_instruction;
  logic        jump_valid;
  logic [15:0] jump_address;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  instruction_fetch #(
    .ADDR_W     (16),
    .DEPTH_LOG2 (2),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .next_instruction           (next_instruction),
    .next_instruction_available (next_instruction_available),
    .ready_for_next_instruction (ready_for_next_instruction),
    .jump_valid                 (jump_valid),
    .jump_address               (jump_address),
    .mem_read                   (mem_read),
    .mem_addr                   (mem_addr),
    .mem_data                   (mem_data),
    .mem_valid                  (mem_valid)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count                (fetch_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [7:0]  mem [0:65535];
  int unsigned fixed_lat;
  bit          rand_lat;
  int unsigned rnd_lat;
  int unsigned wait_cnt;
  int unsigned eff_lat;

  assign eff_lat   = rand_lat ? rnd_lat : fixed_lat;
  assign mem_valid = mem_read && (wait_cnt >= eff_lat);
  assign mem_data  = mem[mem_addr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
      rnd_lat  <= 0;
    end else if (!mem_read || mem_valid) begin
      wait_cnt <= 0;
      if (mem_valid) rnd_lat <= $urandom_range(0, 3);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  logic [15:0] stream_addr;
  int          checks;
  int          fails;
  int          nreads;
  int          model_pops;
  int          since_jump;
  bit          jump_pend;
  bit          hold_valid;
  logic [15:0] hold_addr;

  function automatic logic [23:0] word_at(input logic [15:0] a);
    logic [15:0] a1;
    logic [15:0] a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    return {mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Samples the cycle's outputs (inputs already driven) and updates the stream model.
  task automatic at_neg();
    @(negedge clk);
    if (reset) begin
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_avail", 32'(next_instruction_available), 32'd0);
      chk("rst_instr", 32'(next_instruction), 32'd0);
`ifdef FETCH_COUNT_EN
      chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
      exp_q.delete();
      stream_addr = 16'h0000;
      jump_pend   = 1'b0;
      hold_valid  = 1'b0;
      nreads      = 0;
      model_pops  = 0;
    end else begin
      if (hold_valid) begin
        chk("req_held", 32'(mem_read), 32'd1);
        chk("req_addr_stable", 32'(mem_addr), 32'(hold_addr));
      end
      hold_valid = mem_read && !mem_valid;
      hold_addr  = mem_addr;
      if (!next_instruction_available && !jump_valid)
        chk("empty_instr_zero", 32'(next_instruction), 32'd0);
`ifdef FETCH_COUNT_EN
      chk("fetch_count", 32'(fetch_count), 32'(model_pops[15:0]));
`endif
      if (mem_read && mem_valid) nreads++;
      if (jump_valid) begin
        chk("avail_in_jump", 32'(next_instruction_available), 32'd0);
        exp_q.delete();
        stream_addr = jump_address;
        since_jump  = 0;
        jump_pend   = 1'b1;
      end else begin
        if (jump_pend) since_jump++;
        if (jump_pend && next_instruction_available) begin
          chk("jump_latency_ge4", 32'(since_jump >= 4), 32'd1);
          jump_pend = 1'b0;
        end
        if (next_instruction_available && ready_for_next_instruction) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(word_at(stream_addr));
            stream_addr = stream_addr + 16'd3;
          end
          chk("pop_word", 32'(next_instruction), 32'(exp_q.pop_front()));
          model_pops++;
        end
      end
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_next();
  endtask

  task automatic do_reset();
    reset                      = 1'b1;
    ready_for_next_instruction = 1'b0;
    jump_valid                 = 1'b0;
    jump_address               = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ready;
    logic        jv;
    logic [15:0] ja;
    logic        rd;
    logic [15:0] addr;
    logic        av;
    logic [23:0] ni;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit          found;
    int          rand_pops;
    logic [15:0] ja;
    logic [23:0] wrap_word;

    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    ready_for_next_instruction = 1'b0;
    jump_valid   = 1'b0;
    jump_address = 16'h0000;
    fixed_lat    = 0;
    rand_lat     = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77;
    mem[16'h40] = 8'hA1; mem[16'h41] = 8'hB2; mem[16'h42] = 8'hC3;

    //          ready jv    ja        rd    addr      av    ni
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 24'h000000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 24'h000000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 24'h000000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 24'h332211};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 24'h000000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 24'h000000};
    vecs[6]  = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h0006, 1'b0, 24'h665544};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 24'h000000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 24'h000000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 24'h000000};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0043, 1'b1, 24'hC3B2A1};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b0, 24'h000000};

    // Zero-wait fetch from reset, then a jump coinciding with mem_valid.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ready_for_next_instruction = vecs[i].ready;
      jump_valid   = vecs[i].jv;
      jump_address = vecs[i].ja;
      at_neg();
      chk($sformatf("vec%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_avail", i), 32'(next_instruction_available), 32'(vecs[i].av));
      chk($sformatf("vec%0d_instr", i), 32'(next_instruction), 32'(vecs[i].ni));
      to_next();
    end
    jump_valid = 1'b0;

    // FIFO fills with ready low: 12 byte reads, then no request until one pop.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_neg();
      if (!mem_read) found = 1'b1;
      else to_next();
    end
    chk("wait_entered", 32'(found), 32'd1);
    chk("wait_byte_reads", 32'(nreads), 32'd12);
    chk("wait_head", 32'(next_instruction), 32'(word_at(16'h0000)));
    to_next();
    tick(); tick(); tick();
    at_neg();
    chk("wait_hold_read", 32'(mem_read), 32'd0);
    chk("wait_hold_reads", 32'(nreads), 32'd12);
    to_next();
    ready_for_next_instruction = 1'b1;
    tick();
    ready_for_next_instruction = 1'b0;
    at_neg();
    chk("resume_read", 32'(mem_read), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd12);
    to_next();
    tick(); tick();
    at_neg();
    chk("refill_wait", 32'(mem_read), 32'd0);
    to_next();

    // Slow memory: jump while the request to 0x0005 is outstanding.
    fixed_lat = 3;
    do_reset();
    ready_for_next_instruction = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      at_neg();
      if (mem_read && mem_addr == 16'h0005 && !mem_valid) found = 1'b1;
      to_next();
    end
    chk("found_req5", 32'(found), 32'd1);
    jump_valid   = 1'b1;
    jump_address = 16'h0100;
    at_neg();
    chk("drain_jump_mem_valid", 32'(mem_valid), 32'd0);
    to_next();
    jump_valid = 1'b0;
    at_neg();
    chk("fifo_empty_after_jump", 32'(next_instruction_available), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (i > 0) at_neg();
      chk("drain_addr", 32'(mem_addr), 32'h0005);
      if (mem_valid) found = 1'b1;
      to_next();
    end
    chk("drain_completed", 32'(found), 32'd1);
    at_neg();
    chk("post_drain_read", 32'(mem_read), 32'd1);
    chk("post_drain_addr", 32'(mem_addr), 32'h0100);
    to_next();
    for (int i = 0; i < 40; i++) tick();

    // Address wrap: an instruction straddling 0xFFFF -> 0x0000.
    fixed_lat = 0;
    do_reset();
    ready_for_next_instruction = 1'b1;
    tick(); tick();
    jump_valid   = 1'b1;
    jump_address = 16'hFFFE;
    tick();
    jump_valid = 1'b0;
    at_neg();
    chk("wrap_addr0", 32'(mem_addr), 32'hFFFE);
    to_next();
    at_neg();
    chk("wrap_addr1", 32'(mem_addr), 32'hFFFF);
    to_next();
    at_neg();
    chk("wrap_addr2", 32'(mem_addr), 32'h0000);
    to_next();
    wrap_word = {mem[0], mem[16'hFFFF], mem[16'hFFFE]};
    at_neg();
    chk("wrap_avail", 32'(next_instruction_available), 32'd1);
    chk("wrap_word", 32'(next_instruction), 32'(wrap_word));
    to_next();
    for (int i = 0; i < 6; i++) tick();

`ifdef FETCH_COUNT_EN
    // Five pops, then a jump while a word is available.
    do_reset();
    ready_for_next_instruction = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      at_neg();
      if (model_pops >= 5) found = 1'b1;
      to_next();
    end
    chk("five_pops", 32'(model_pops), 32'd5);
    ready_for_next_instruction = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      at_neg();
      if (next_instruction_available) found = 1'b1;
      to_next();
    end
    chk("fc_avail_found", 32'(found), 32'd1);
    ready_for_next_instruction = 1'b1;
    jump_valid   = 1'b1;
    jump_address = 16'h0200;
    at_neg();
    chk("fc_jump_avail", 32'(next_instruction_available), 32'd0);
    chk("fc_jump_count", 32'(fetch_count), 32'd5);
    to_next();
    jump_valid = 1'b0;
    at_neg();
    chk("fc_after_jump", 32'(fetch_count), 32'd5);
    to_next();
`endif

    // Randomized: latency 0..3, random ready, random jumps, one mid-run reset.
    rand_lat = 1'b1;
    do_reset();
    rand_pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
      end
      ready_for_next_instruction = ($urandom_range(0, 3) != 0);
      ja = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ja = 16'hFFFC + 16'($urandom_range(0, 3));
      jump_valid   = ($urandom_range(0, 40) == 0);
      jump_address = ja;
      if (next_instruction_available && ready_for_next_instruction && !jump_valid)
        rand_pops++;
      tick();
    end
    jump_valid = 1'b0;
    chk("rand_progress", 32'(rand_pops > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end producer for the three-stage instruction pipeline. It reads the instruction stream one byte at a time from a byte-wide memory port and assembles 24-bit little-endian instructions. It buffers them in a small prefetch FIFO and offers them on the pipeline's `next_instruction` / `next_instruction_available` / `ready_for_next_instruction` handshake. Jumps from later stages flush the buffer and redirect fetching.

## Interface
- `ADDR_W`, 16, byte-address width; the PC wraps modulo 2^ADDR_W.
- `DEPTH_LOG2`, 2, prefetch FIFO depth = 2^DEPTH_LOG2 instructions (minimum 1).
- `RESET_ADDR`, 0, first fetch address after reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `next_instruction` out 24: FIFO head instruction; drives 0 when the FIFO is empty.
- `next_instruction_available` out 1: high when the FIFO is not empty and `jump_valid` is low.
- `ready_for_next_instruction` in 1: the pipeline latches `next_instruction` at this edge.
- `jump_valid` in 1: redirect request, valid for one cycle per jump.
- `jump_address` in ADDR_W: new PC, sampled when `jump_valid` is high.
- `mem_read` out 1: byte read request.
- `mem_addr` out ADDR_W: request address; stable while `mem_read` is high and `mem_valid` is low.
- `mem_data` in 8: read data; valid when `mem_valid` is high.
- `mem_valid` in 1: completes the current request. It may be high in the same cycle as `mem_read`.

## Operation
- State: `pc`, request address register, byte counter (0..2), 16-bit assembly register, FIFO with read/write pointers and a count.
- FSM states:
  - FETCH: `mem_read`=1 with `mem_addr`. On an edge with `mem_valid`:
    - Byte k goes into bits [8k+7:8k]. Byte 0 is the LSB.
    - `pc`/`mem_addr` increment by 1, wrapping.
    - The counter advances. After byte 2, the assembled word is pushed and the counter returns to 0.
  - WAIT: `mem_read`=0. Entered when the counter is 0 and the FIFO is full, or will be full after a push in this cycle. Returns to FETCH on the edge where the FIFO count drops below depth. A byte-0 request is never issued without a free slot.
  - DRAIN: `mem_read`=1 with the old `mem_addr`. The next `mem_valid` byte is discarded. Then `mem_addr`←`pc` and the FSM enters FETCH, or WAIT per the rule above.
- Pop: on an edge with `next_instruction_available` & `ready_for_next_instruction`. Push and pop may occur on the same edge; the count is then unchanged. A push into a full FIFO cannot occur.
- Jump (highest priority), on an edge with `jump_valid`:
  - The FIFO is cleared with no pop, the counter is set to 0, and `pc`←`jump_address`.
  - If the FSM is in FETCH with `mem_valid` low, it enters DRAIN.
  - If `mem_valid` is high on the same edge, the byte is discarded, `mem_addr`←`jump_address`, and the FSM enters FETCH.
  - If the FSM is in WAIT, `mem_addr`←`jump_address` and it enters FETCH.
  - If the FSM is in DRAIN, only `pc` updates. It stays in DRAIN unless `mem_valid` is high on that edge, in which case it enters FETCH.
- Reset:
  - FIFO empty, `next_instruction`=0, `next_instruction_available`=0, `mem_read`=0.
  - `pc`=`mem_addr`=RESET_ADDR, counter 0, FSM in FETCH, with `mem_read` rising in the first cycle after deassertion.
  - Reset during any state, including an outstanding request, abandons everything. The memory must tolerate the dropped request.

## Timing
- Zero-wait memory: one byte per cycle, one instruction per 3 cycles.
- Latency: the instruction is available in the cycle after the edge that captured its byte 2.
- After a jump in FETCH with no `mem_valid`: the drained response takes at least 1 cycle, then 3 cycles of fetch. The first new instruction is available no earlier than 4 cycles after the jump edge.
- `next_instruction_available` falls combinationally with `jump_valid`, so the pipeline latches a NOP in the jump cycle.
- `ready_for_next_instruction` affects only the pop. It has no combinational path to memory outputs.

## Configuration
- `FETCH_COUNT_EN`:
  - Defined: adds output `fetch_count` [15:0], reset to 0, incremented on every pop and wrapping at 0xFFFF. Pops are suppressed on jump edges, so jump edges never count.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset with RESET_ADDR=0, zero-wait memory holding 0x11,0x22,0x33, pipeline ready=1 -> `mem_addr` steps 0,1,2. `next_instruction`=0x332211 with available=1 in cycle 4.
- Ready held 0, DEPTH_LOG2=2 -> exactly 4 words pushed (12 byte reads), then `mem_read`=0 in WAIT. Ready for one cycle -> one pop, and fetch resumes at address 12.
- Memory with 3-cycle `mem_valid` delay; jump to 0x0100 while a request to 0x0005 is outstanding -> `mem_addr` stays 0x0005 until `mem_valid`, that byte is dropped, next request is at 0x0100, and the FIFO is empty after the jump edge.
- Jump with `mem_valid` on the same edge -> byte discarded, next cycle `mem_read`=1 at `jump_address`, no DRAIN cycle.
- PC at 2^ADDR_W−1 -> next request at 0. The instruction spanning the wrap assembles correctly.
- With `FETCH_COUNT_EN`: 5 pops, then a jump while available -> `fetch_count`=5 and available=0 during the jump cycle.
